// File: rtl/iq2phase_if.sv
// Sample/phase bus between the Hilbert filter, the iq2phase CORDIC stage and the speed averager.
interface iq2phase_if;
  logic               sample_in;
  logic signed [15:0] i_in;
  logic signed [15:0] q_in;
  logic signed [18:0] phase;
  logic               sample;
  logic               busy;
  logic               overrun;

  modport master (
    output sample_in, i_in, q_in,
    input  phase, sample, busy, overrun
  );

  modport slave (
    input  sample_in, i_in, q_in,
    output phase, sample, busy, overrun
  );
endinterface

// File: rtl/iq2phase.sv
// Vectoring CORDIC angle of each I/Q sample, emitted as the wrapped phase increment (9Q10 rad)
// since the previous sample, with a one-cycle strobe.
module iq2phase #(
  parameter int ITER = 14
) (
  input  logic       clock,
  input  logic       reset,
  iq2phase_if.slave  bus
);

  localparam int KW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(ITER - 1);

  localparam logic signed [17:0] HALF_PI = 18'sd25736;
  localparam logic signed [18:0] PI_Q14  = 19'sd51472;
  localparam logic signed [18:0] TWO_PI  = 19'sd102944;

  typedef enum logic [1:0] {IDLE, ROT, DIFF} state_t;

  state_t             r_state, w_next;
  logic [KW-1:0]      r_k;
  logic signed [19:0] r_x, r_y;
  logic signed [17:0] r_z, r_z_prev;
  logic               r_zero;
  logic               r_primed;
  logic signed [18:0] r_phase;
  logic               r_sample;
  logic               r_overrun;

  logic signed [19:0] w_i_ext, w_q_ext;
  logic signed [19:0] w_x0, w_y0;
  logic signed [17:0] w_z0;
  logic               w_zero;
  logic               w_d_pos;
  logic signed [19:0] w_x_sh, w_y_sh, w_x_nxt, w_y_nxt;
  logic signed [17:0] w_atan, w_z_nxt;
  logic signed [18:0] w_diff, w_wrap, w_rnd, w_phase;

  function automatic logic signed [17:0] atan_q14(input int k);
    case (k)
      0:       return 18'sd12868;
      1:       return 18'sd7596;
      2:       return 18'sd4014;
      3:       return 18'sd2037;
      4:       return 18'sd1023;
      5:       return 18'sd512;
      6:       return 18'sd256;
      7:       return 18'sd128;
      8:       return 18'sd64;
      9:       return 18'sd32;
      10:      return 18'sd16;
      11:      return 18'sd8;
      12:      return 18'sd4;
      13:      return 18'sd2;
      14:      return 18'sd1;
      default: return 18'sd0;
    endcase
  endfunction

  // Inputs widened to 20 bits and scaled by 4 so that negating -32768 cannot overflow.
  assign w_i_ext = {{2{bus.i_in[15]}}, bus.i_in, 2'b00};
  assign w_q_ext = {{2{bus.q_in[15]}}, bus.q_in, 2'b00};
  assign w_zero  = (bus.i_in == 16'sd0) && (bus.q_in == 16'sd0);

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    w_x0 = w_i_ext;
    w_y0 = w_q_ext;
    w_z0 = 18'sd0;
    if (bus.i_in[15]) begin
      if (!bus.q_in[15]) begin
        w_x0 = w_q_ext;
        w_y0 = -w_i_ext;
        w_z0 = HALF_PI;
      end else begin
        w_x0 = -w_q_ext;
        w_y0 = w_i_ext;
        w_z0 = -HALF_PI;
      end
    end
  end

  // One micro-rotation; x and y both update from their old values.
  assign w_d_pos = ~r_y[19];
  assign w_x_sh  = r_x >>> r_k;
  assign w_y_sh  = r_y >>> r_k;
  assign w_atan  = atan_q14(int'(r_k));
  assign w_x_nxt = w_d_pos ? (r_x + w_y_sh) : (r_x - w_y_sh);
  assign w_y_nxt = w_d_pos ? (r_y - w_x_sh) : (r_y + w_x_sh);
  // A zero vector has no angle; z is held at 0 while the rotations still run for fixed latency.
  assign w_z_nxt = r_zero ? r_z : (w_d_pos ? (r_z + w_atan) : (r_z - w_atan));

  assign w_diff = {r_z[17], r_z} - {r_z_prev[17], r_z_prev};

  always_comb begin
    w_wrap = w_diff;
    if (w_diff > PI_Q14)
      w_wrap = w_diff - TWO_PI;
    else if (w_diff <= -PI_Q14)
      w_wrap = w_diff + TWO_PI;
  end

  assign w_rnd   = w_wrap + 19'sd8;
  assign w_phase = w_rnd >>> 4;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.sample_in) w_next = ROT;
      ROT:     if (r_k == K_LAST) w_next = DIFF;
      DIFF:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_z_prev  <= '0;
      r_primed  <= 1'b0;
      r_phase   <= '0;
      r_sample  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_sample <= 1'b0;
      if (bus.sample_in && (r_state != IDLE))
        r_overrun <= 1'b1;
      if (r_state == DIFF) begin
        r_z_prev <= r_z;
        r_primed <= 1'b1;
        if (r_primed) begin
          r_phase  <= w_phase;
          r_sample <= 1'b1;
        end
      end
    end
  end

  // NOTE: the CORDIC datapath is always loaded at capture before it is read, so it carries no reset.
  always_ff @(posedge clock) begin
    case (r_state)
      IDLE: begin
        if (bus.sample_in) begin
          r_x    <= w_x0;
          r_y    <= w_y0;
          r_z    <= w_z0;
          r_zero <= w_zero;
          r_k    <= '0;
        end
      end
      ROT: begin
        r_x <= w_x_nxt;
        r_y <= w_y_nxt;
        r_z <= w_z_nxt;
        r_k <= r_k + KW'(1);
      end
      default: ;
    endcase
  end

  assign bus.phase   = r_phase;
  assign bus.sample  = r_sample;
  assign bus.busy    = (r_state != IDLE);
  assign bus.overrun = r_overrun;

endmodule

// File: tb/tb_iq2phase.sv
// Directed bench for iq2phase: priming, latency, wrap, quadrant edges, overrun, zero vector, reset abort.
module tb_iq2phase;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  iq2phase_if bus();

  iq2phase #(.ITER(14)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Phasor of amplitude 20000 at k*pi/8, k = 0..15.
  logic signed [15:0] rot_i [16] = '{16'sd20000, 16'sd18478, 16'sd14142, 16'sd7654,
                                     16'sd0, -16'sd7654, -16'sd14142, -16'sd18478,
                                     -16'sd20000, -16'sd18478, -16'sd14142, -16'sd7654,
                                     16'sd0, 16'sd7654, 16'sd14142, 16'sd18478};
  logic signed [15:0] rot_q [16] = '{16'sd0, 16'sd7654, 16'sd14142, 16'sd18478,
                                     16'sd20000, 16'sd18478, 16'sd14142, 16'sd7654,
                                     16'sd0, -16'sd7654, -16'sd14142, -16'sd18478,
                                     -16'sd20000, -16'sd18478, -16'sd14142, -16'sd7654};

  task automatic apply_reset(input int cycles);
    @(negedge clock);
    reset = 1'b1;
    bus.sample_in = 1'b0;
    repeat (cycles) @(negedge clock);
    reset = 1'b0;
  endtask

  // Returns at the negedge just after the accepting edge.
  task automatic send(input logic signed [15:0] i, input logic signed [15:0] q);
    @(negedge clock);
    bus.i_in = i;
    bus.q_in = q;
    bus.sample_in = 1'b1;
    @(negedge clock);
    bus.sample_in = 1'b0;
  endtask

  task automatic wait_strobe(input int limit, output int lat, output bit got);
    lat = 0;
    got = 1'b0;
    while (!got && lat < limit) begin
      @(negedge clock);
      lat++;
      if (bus.sample === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    int lat, p;
    bit got;
    apply_reset(2);
    n_vec++;
    if ({bus.phase, bus.sample, bus.busy, bus.overrun} !== 22'd0) begin
      n_err++;
      $display("FAIL reset_init: outputs=%h required 0", {bus.phase, bus.sample, bus.busy, bus.overrun});
    end
    send(16'sd20000, 16'sd0);
    wait_strobe(20, lat, got);
    send(16'sd0, 16'sd20000);
    wait_strobe(20, lat, got);
    p = bus.phase;
    n_vec++;
    if (!got || $isunknown(bus.phase) || p < 1606 || p > 1610) begin
      n_err++;
      $display("FAIL reset_pre: phase=%0d strobe=%0b required 1608+-2", p, got);
    end
    // Start a computation, drop a sample into it, then reset mid-ROT.
    send(-16'sd20000, 16'sd0);
    repeat (3) @(negedge clock);
    bus.sample_in = 1'b1;
    @(negedge clock);
    bus.sample_in = 1'b0;
    apply_reset(2);
    n_vec++;
    if ({bus.phase, bus.sample, bus.busy, bus.overrun} !== 22'd0) begin
      n_err++;
      $display("FAIL reset_mid_rot: outputs=%h required 0", {bus.phase, bus.sample, bus.busy, bus.overrun});
    end
    wait_strobe(25, lat, got);
    n_vec++;
    if (got !== 1'b0) begin
      n_err++;
      $display("FAIL reset_abort: strobe seen at %0d, required none", lat);
    end
    send(16'sd20000, 16'sd0);
    wait_strobe(20, lat, got);
    n_vec++;
    if (got !== 1'b0) begin
      n_err++;
      $display("FAIL reset_reprime: strobe seen at %0d, required none", lat);
    end
    send(16'sd0, 16'sd20000);
    wait_strobe(20, lat, got);
    p = bus.phase;
    n_vec++;
    if (!got || lat != 15 || p < 1606 || p > 1610) begin
      n_err++;
      $display("FAIL reset_post: phase=%0d strobe=%0b lat=%0d required 1608+-2 lat 15", p, got, lat);
    end
  endtask

  task automatic test_positive_rotation();
    int lat, p;
    bit got;
    apply_reset(2);
    for (int s = 0; s < 20; s++) begin
      send(rot_i[s % 16], rot_q[s % 16]);
      wait_strobe(18, lat, got);
      p = bus.phase;
      n_vec++;
      if (s == 0) begin
        if (got !== 1'b0) begin
          n_err++;
          $display("FAIL rot_prime: strobe at %0d, required none", lat);
        end
      end else if (!got || lat != 15 || $isunknown(bus.phase) || p < 400 || p > 404) begin
        n_err++;
        $display("FAIL rot_step%0d: phase=%0d strobe=%0b lat=%0d required 402+-2 lat 15", s, p, got, lat);
      end
      repeat (18 - lat) @(negedge clock);
    end
  endtask

  task automatic test_wrap();
    int lat, p;
    bit got;
    apply_reset(2);
    send(-16'sd19696, 16'sd3473);
    wait_strobe(20, lat, got);
    send(-16'sd19696, -16'sd3473);
    wait_strobe(20, lat, got);
    p = bus.phase;
    n_vec++;
    if (!got || p < 355 || p > 359) begin
      n_err++;
      $display("FAIL wrap_fwd: phase=%0d strobe=%0b required 357+-2", p, got);
    end
    send(-16'sd19696, 16'sd3473);
    wait_strobe(20, lat, got);
    p = bus.phase;
    n_vec++;
    if (!got || p < -359 || p > -355) begin
      n_err++;
      $display("FAIL wrap_rev: phase=%0d strobe=%0b required -357+-2", p, got);
    end
  endtask

  task automatic test_quadrants();
    logic signed [15:0] qi [5] = '{16'sd32767, 16'sd0, -16'sd32768, 16'sd0, 16'sd32767};
    logic signed [15:0] qq [5] = '{16'sd0, 16'sd32767, 16'sd0, -16'sd32768, 16'sd0};
    int lat, p;
    bit got;
    apply_reset(2);
    for (int s = 0; s < 5; s++) begin
      send(qi[s], qq[s]);
      wait_strobe(20, lat, got);
      if (s > 0) begin
        p = bus.phase;
        n_vec++;
        if (!got || $isunknown(bus.phase) || p < 1606 || p > 1610) begin
          n_err++;
          $display("FAIL quad_step%0d: phase=%0d strobe=%0b required 1608+-2", s, p, got);
        end
      end
    end
  endtask

  task automatic test_overrun();
    int lat, p;
    bit got;
    apply_reset(2);
    send(16'sd20000, 16'sd0);
    wait_strobe(20, lat, got);
    send(16'sd0, 16'sd20000);
    n_vec++;
    if ({bus.busy, bus.overrun} !== 2'b10) begin
      n_err++;
      $display("FAIL ovr_before: busy,overrun=%b required 10", {bus.busy, bus.overrun});
    end
    repeat (4) @(negedge clock);
    bus.i_in = -16'sd20000;
    bus.q_in = 16'sd0;
    bus.sample_in = 1'b1;
    @(negedge clock);
    bus.sample_in = 1'b0;
    n_vec++;
    if (bus.overrun !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_set: overrun=%b required 1", bus.overrun);
    end
    lat = 5;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clock);
      lat++;
      if (bus.sample === 1'b1) got = 1'b1;
    end
    p = bus.phase;
    n_vec++;
    if (!got || lat != 15 || p < 1606 || p > 1610) begin
      n_err++;
      $display("FAIL ovr_inflight: phase=%0d strobe=%0b lat=%0d required 1608+-2 lat 15", p, got, lat);
    end
    // Sample presented in the strobe cycle must be accepted.
    bus.i_in = -16'sd20000;
    bus.q_in = 16'sd0;
    bus.sample_in = 1'b1;
    @(negedge clock);
    bus.sample_in = 1'b0;
    n_vec++;
    if (bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_accept: busy=%b required 1", bus.busy);
    end
    wait_strobe(20, lat, got);
    p = bus.phase;
    n_vec++;
    if (!got || lat != 15 || p < 1606 || p > 1610 || bus.overrun !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_next: phase=%0d strobe=%0b lat=%0d overrun=%b required 1608+-2 lat 15 overrun 1",
               p, got, lat, bus.overrun);
    end
  endtask

  task automatic test_zero();
    int lat, p;
    bit got;
    apply_reset(2);
    send(16'sd14142, 16'sd14142);
    wait_strobe(20, lat, got);
    send(16'sd0, 16'sd0);
    wait_strobe(20, lat, got);
    p = bus.phase;
    n_vec++;
    if (!got || $isunknown(bus.phase) || p < -806 || p > -802) begin
      n_err++;
      $display("FAIL zero_input: phase=%0d strobe=%0b required -804+-2", p, got);
    end
  endtask

  initial begin
    bus.sample_in = 1'b0;
    bus.i_in = '0;
    bus.q_in = '0;
    test_reset();
    test_positive_rotation();
    test_wrap();
    test_quadrants();
    test_overrun();
    test_zero();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
